// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI master between N_REQ requesters; sequences m_en/m_busy and returns rx byte.
// Latency: req sampled in IDLE -> m_en in the next cycle; m_busy fall -> done pulse in the next cycle.
// Backpressure: requesters hold level req until their one-cycle done; the master stalls via m_busy, bounded by TIMEOUT before busy rises.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req / req_addr / req_clk_sel / req_data   per-requester request level and packed transfer fields
//   gnt, done, err, rx_data        one-hot grant, one-hot completion pulse, timeout flag, received byte
//   ctrl_busy                      high whenever a transaction is in flight
//   m_en, m_addr, m_clk_sel, m_data_in, m_busy, m_data_out   SPI master interface
module spi_req_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [4*N_REQ-1:0]   req_addr,
    input  logic [3*N_REQ-1:0]   req_clk_sel,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic                 err,
    output logic [7:0]           rx_data,
    output logic                 ctrl_busy,
    output logic                 m_en,
    output logic [3:0]           m_addr,
    output logic [2:0]           m_clk_sel,
    output logic [7:0]           m_data_in,
    input  logic                 m_busy,
    input  logic [7:0]           m_data_out
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        XFER,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  rr;
    logic [IDX_W-1:0]  win_idx;
    logic              win_vld;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_expired;

    // Scan downward in offset so the lowest offset from rr+1 is the last
    // (and therefore winning) assignment.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req[(int'(rr) + k) % N_REQ]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'((int'(rr) + k) % N_REQ);
            end
        end
    end

    assign cnt_expired = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // m_busy is checked before the timeout so a busy rise in the expiry
    // cycle still proceeds to the transfer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (win_vld) state_next = START;
            START:     state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (m_busy) begin
                    state_next = XFER;
                end else if (cnt_expired) begin
                    state_next = DONE;
                end
            end
            XFER:      if (!m_busy) state_next = DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Decoded straight from the state register so m_en drops on the same
    // edge that leaves XFER or applies reset.
    assign m_en = (state == START) || (state == WAIT_BUSY) || (state == XFER);
    assign done = (state == DONE) ? gnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr        <= IDX_W'(N_REQ - 1);
            gnt       <= '0;
            err       <= 1'b0;
            rx_data   <= '0;
            ctrl_busy <= 1'b0;
            m_addr    <= '0;
            m_clk_sel <= '0;
            m_data_in <= '0;
            cnt       <= '0;
        end else begin
            ctrl_busy <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        gnt       <= N_REQ'(1) << win_idx;
                        rr        <= win_idx;
                        m_addr    <= req_addr[4*win_idx +: 4];
                        m_clk_sel <= req_clk_sel[3*win_idx +: 3];
                        m_data_in <= req_data[8*win_idx +: 8];
                    end
                end
                START: begin
                    cnt <= '0;
                end
                WAIT_BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (!m_busy && cnt_expired) begin
                        err <= 1'b1;
                    end
                end
                XFER: begin
                    if (!m_busy) begin
                        rx_data <= m_data_out;
                    end
                end
                DONE: begin
                    gnt <= '0;
                    err <= 1'b0;
                end
                default: begin
                    gnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_req_arbiter.sv
module tb_spi_req_arbiter;

    localparam int N  = 4;
    localparam int TO = 255;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req;
    logic [4*N-1:0]   req_addr;
    logic [3*N-1:0]   req_clk_sel;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     gnt;
    logic [N-1:0]     done;
    logic             err;
    logic [7:0]       rx_data;
    logic             ctrl_busy;
    logic             m_en;
    logic [3:0]       m_addr;
    logic [2:0]       m_clk_sel;
    logic [7:0]       m_data_in;
    logic             m_busy;
    logic [7:0]       m_data_out;

    spi_req_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_addr   (req_addr),
        .req_clk_sel(req_clk_sel),
        .req_data   (req_data),
        .gnt        (gnt),
        .done       (done),
        .err        (err),
        .rx_data    (rx_data),
        .ctrl_busy  (ctrl_busy),
        .m_en       (m_en),
        .m_addr     (m_addr),
        .m_clk_sel  (m_clk_sel),
        .m_data_in  (m_data_in),
        .m_busy     (m_busy),
        .m_data_out (m_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_err = 0;
    int         rr_m;          // model: last granted requester
    logic [7:0] rx_exp;        // model: value rx_data should hold
    logic [N-1:0] last_gnt;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Round-robin rule: first pending requester after the last winner, wrapping.
    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        m_busy = 1'b0;
        m_data_out = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rr_m = N - 1;
        rx_exp = '0;
    endtask

    // Called at a negedge in IDLE with req already driven. d = WAIT_BUSY cycle
    // in which the master raises busy (d >= TO means never); len = busy cycles.
    task automatic run_txn(input int d, input int len, input logic [7:0] rx_val,
                           input bit keep, input bit drop, input bit rst_mid);
        int         win;
        int         n_wait;
        bit         timed_out;
        logic [3:0] s_addr;
        logic [2:0] s_sel;
        logic [7:0] s_data;
        win = pick(req, rr_m);
        if (win < 0) return;
        s_addr = req_addr[4*win +: 4];
        s_sel  = req_clk_sel[3*win +: 3];
        s_data = req_data[8*win +: 8];
        rr_m   = win;

        @(negedge clk);   // START
        last_gnt = gnt;
        chk("gnt", gnt, 32'(1) << win);
        chk("m_en_start", m_en, 1);
        chk("m_addr", m_addr, s_addr);
        chk("m_clk_sel", m_clk_sel, s_sel);
        chk("m_data_in", m_data_in, s_data);
        chk("ctrl_busy_start", ctrl_busy, 1);

        timed_out = (d >= TO);
        n_wait = timed_out ? TO : d + 1;
        for (int j = 0; j < n_wait; j++) begin
            @(negedge clk);   // WAIT_BUSY cycle j
            if (drop && j == 1) begin
                req[win] = 1'b0;
                req_data[8*win +: 8] = 8'hFF;
            end
            if (j == d) m_busy = 1'b1;
            if (j == n_wait - 1) begin
                chk("wait_m_en", m_en, 1);
                chk("wait_no_done", done, 0);
            end
        end

        if (timed_out) begin
            @(negedge clk);   // DONE
            chk("to_done", done, 32'(1) << win);
            chk("to_err", err, 1);
            chk("to_m_en", m_en, 0);
            chk("to_rx_held", rx_data, rx_exp);
        end else begin
            for (int x = 0; x < len; x++) begin
                @(negedge clk);   // XFER cycle x
                if (x == 0) begin
                    chk("xfer_m_en", m_en, 1);
                    chk("xfer_no_done", done, 0);
                    if (rst_mid) begin
                        rst = 1'b1;
                        @(negedge clk);
                        chk("rst_m_en", m_en, 0);
                        chk("rst_gnt", gnt, 0);
                        chk("rst_ctrl_busy", ctrl_busy, 0);
                        chk("rst_done", done, 0);
                        chk("rst_err", err, 0);
                        chk("rst_rx", rx_data, 0);
                        rst = 1'b0;
                        m_busy = 1'b0;
                        req = '0;
                        rr_m = N - 1;
                        rx_exp = '0;
                        return;
                    end
                end
                if (x == len - 1) begin
                    m_busy = 1'b0;
                    m_data_out = rx_val;
                end else begin
                    m_data_out = 8'($urandom);
                end
            end
            @(negedge clk);   // DONE
            chk("done", done, 32'(1) << win);
            chk("done_err", err, 0);
            chk("done_m_en", m_en, 0);
            chk("rx_data", rx_data, rx_val);
            chk("latched_data", m_data_in, s_data);
            rx_exp = rx_val;
        end
        if (!keep) req[win] = 1'b0;

        @(negedge clk);   // back in IDLE
        chk("idle_done", done, 0);
        chk("idle_gnt", gnt, 0);
        chk("idle_ctrl_busy", ctrl_busy, 0);
        chk("idle_m_en", m_en, 0);
        chk("idle_err", err, 0);
        chk("idle_rx_held", rx_data, rx_exp);
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        req_addr = '0;
        req_clk_sel = '0;
        req_data = '0;
        m_busy = 1'b0;
        m_data_out = '0;
        last_gnt = '0;

        // Reset state
        do_reset();
        chk("rst_gnt0", gnt, 0);
        chk("rst_done0", done, 0);
        chk("rst_err0", err, 0);
        chk("rst_m_en0", m_en, 0);
        chk("rst_busy0", ctrl_busy, 0);
        chk("rst_rx0", rx_data, 0);
        chk("rst_addr0", m_addr, 0);
        chk("rst_sel0", m_clk_sel, 0);
        chk("rst_din0", m_data_in, 0);

        // Single request on requester 2: busy 3 cycles after m_en, 16 long
        req_addr[11:8]   = 4'h8;
        req_clk_sel[8:6] = 3'd3;
        req_data[23:16]  = 8'hA5;
        req = 4'b0100;
        run_txn(2, 16, 8'h3C, 1'b0, 1'b0, 1'b0);
        chk("single_gnt", last_gnt, 4'b0100);

        // All requesters held from reset: grants 0,1,2,3,0
        do_reset();
        req_addr = 16'h4321;
        req_clk_sel = 12'o7531;
        req_data = 32'hDEADBEEF;
        req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            run_txn(1, 2, 8'(k + 8'h10), 1'b1, 1'b0, 1'b0);
            chk("rr_order", last_gnt, 32'(1) << (k % N));
        end

        // Timeout on requester 1: master never raises busy
        req = 4'b0010;
        run_txn(TO, 1, 8'h00, 1'b0, 1'b0, 1'b0);

        // m_busy rises in the very cycle the counter expires
        req = 4'b0100;
        run_txn(TO - 1, 3, 8'h5A, 1'b0, 1'b0, 1'b0);

        // Reset during XFER, then requester 0 served normally
        req = 4'b0100;
        run_txn(2, 4, 8'h77, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("post_rst_no_done", done, 0);
        req = 4'b0001;
        run_txn(1, 3, 8'hC3, 1'b0, 1'b0, 1'b0);

        // Requester 3 drops req and changes its data after grant
        req_data[31:24] = 8'h42;
        req = 4'b1000;
        run_txn(3, 4, 8'h99, 1'b0, 1'b1, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    req_addr[4*i +: 4]    = 4'($urandom);
                    req_clk_sel[3*i +: 3] = 3'($urandom);
                    req_data[8*i +: 8]    = 8'($urandom);
                    if ($urandom_range(0, 1) == 1) req[i] = 1'b1;
                end else if ($urandom_range(0, 7) == 0) begin
                    req[i] = 1'b0;   // withdrawn before grant
                end
            end
            if (req == '0) req[$urandom_range(0, N - 1)] = 1'b1;
            run_txn(($urandom_range(0, 9) == 0) ? TO - 1 : int'($urandom_range(0, 6)),
                    int'($urandom_range(1, 6)), 8'($urandom),
                    ($urandom_range(0, 3) == 0), 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
